// File: rtl/josh_pkg.sv
// Shared constants, FSM state type and packed-bus indexing helper for the
// sprite render engine.
package josh_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] BLACK = 3'd0;
    localparam logic [2:0] WHITE = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ERASE,
        DRAW,
        FINISH
    } state_t;

    // LSB position of field idx in a bus of equal-width packed fields
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major rectangle walker: dx runs fastest, then dy. Reports the screen
// position of the current step, whether it lies on screen, and the last step.
module rect_scanner #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           clear,
    input  logic           step,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] px,
    output logic [Y_W-1:0] py,
    output logic           in_bounds,
    output logic           last
);

    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    logic [X_W:0]   px_full;
    logic [Y_W:0]   py_full;
    logic           row_end;

    // One extra bit so objects hanging off the right/bottom edge do not wrap
    assign px_full   = {1'b0, base_x} + {1'b0, dx};
    assign py_full   = {1'b0, base_y} + {1'b0, dy};
    assign px        = px_full[X_W-1:0];
    assign py        = py_full[Y_W-1:0];
    assign in_bounds = (px_full < X_LIM) && (py_full < Y_LIM);
    assign row_end   = (dx == w - X_W'(1));
    assign last      = row_end && (dy == h - Y_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            dx <= '0;
            dy <= '0;
        end else if (step) begin
            if (row_end) begin
                dx <= '0;
                dy <= dy + Y_W'(1);
            end else begin
                dx <= dx + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_render_engine.sv
// Multi-object frame renderer feeding the VGA plot port: erase old rectangles,
// draw new ones, one position per cycle. Build with FULL_CLEAR_EN to replace
// the per-object erase with a full-screen background scan.
module sprite_render_engine
    import josh_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int NUM_OBJ  = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [NUM_OBJ-1:0]           obj_en,
    input  logic [NUM_OBJ*X_W-1:0]       obj_x,
    input  logic [NUM_OBJ*Y_W-1:0]       obj_y,
    input  logic [NUM_OBJ*X_W-1:0]       obj_w,
    input  logic [NUM_OBJ*Y_W-1:0]       obj_h,
    input  logic [NUM_OBJ*COLOUR_W-1:0]  obj_colour,
    input  logic [COLOUR_W-1:0]          bg_colour,
    output logic                         plot,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    state_t state, state_n;
    logic [IDX_W-1:0] idx, idx_n;

    logic [NUM_OBJ-1:0]          cur_en;
    logic [NUM_OBJ*X_W-1:0]      cur_x, cur_w;
    logic [NUM_OBJ*Y_W-1:0]      cur_y, cur_h;
    logic [NUM_OBJ*COLOUR_W-1:0] cur_c;
    logic [COLOUR_W-1:0]         cur_bg;
`ifndef FULL_CLEAR_EN
    logic [NUM_OBJ-1:0]          prev_en;
    logic [NUM_OBJ*X_W-1:0]      prev_x, prev_w;
    logic [NUM_OBJ*Y_W-1:0]      prev_y, prev_h;
`endif

    logic                sel_en, ent_live, ent_final;
    logic [X_W-1:0]      sel_x, sel_w;
    logic [Y_W-1:0]      sel_y, sel_h;
    logic [COLOUR_W-1:0] pix_colour;
    logic                sc_clear, sc_step, sc_in_bounds, sc_last, pix_vld;
    logic [X_W-1:0]      sc_px;
    logic [Y_W-1:0]      sc_py;

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

    // Current entry: erase walks the previous frame (or the whole screen),
    // draw walks this frame's snapshot.
    always_comb begin
        sel_en     = cur_en[idx];
        sel_x      = cur_x[field_lsb(int'(idx), X_W) +: X_W];
        sel_y      = cur_y[field_lsb(int'(idx), Y_W) +: Y_W];
        sel_w      = cur_w[field_lsb(int'(idx), X_W) +: X_W];
        sel_h      = cur_h[field_lsb(int'(idx), Y_W) +: Y_W];
        pix_colour = cur_c[field_lsb(int'(idx), COLOUR_W) +: COLOUR_W];
        ent_final  = (idx == IDX_W'(NUM_OBJ - 1));
        if (state == ERASE) begin
            pix_colour = cur_bg;
`ifdef FULL_CLEAR_EN
            sel_en    = 1'b1;
            sel_x     = '0;
            sel_y     = '0;
            sel_w     = X_W'(SCREEN_W);
            sel_h     = Y_W'(SCREEN_H);
            ent_final = 1'b1;
`else
            sel_en = prev_en[idx];
            sel_x  = prev_x[field_lsb(int'(idx), X_W) +: X_W];
            sel_y  = prev_y[field_lsb(int'(idx), Y_W) +: Y_W];
            sel_w  = prev_w[field_lsb(int'(idx), X_W) +: X_W];
            sel_h  = prev_h[field_lsb(int'(idx), Y_W) +: Y_W];
`endif
        end
        ent_live = sel_en && (sel_w != '0) && (sel_h != '0);
    end

    rect_scanner #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (sc_clear),
        .step      (sc_step),
        .base_x    (sel_x),
        .base_y    (sel_y),
        .w         (sel_w),
        .h         (sel_h),
        .px        (sc_px),
        .py        (sc_py),
        .in_bounds (sc_in_bounds),
        .last      (sc_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        sc_clear = 1'b0;
        sc_step  = 1'b0;
        pix_vld  = 1'b0;
        case (state)
            IDLE: begin
                sc_clear = 1'b1;
                if (start) state_n = LATCH;
            end
            LATCH: begin
                sc_clear = 1'b1;
                idx_n    = '0;
                state_n  = ERASE;
            end
            ERASE, DRAW: begin
                pix_vld = ent_live && sc_in_bounds;
                // Skipped entries still burn one cycle
                if (!ent_live || sc_last) begin
                    sc_clear = 1'b1;
                    if (ent_final) begin
                        idx_n   = '0;
                        state_n = (state == ERASE) ? DRAW : FINISH;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    sc_step = 1'b1;
                end
            end
            FINISH: begin
                sc_clear = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx    <= '0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= COLOUR_W'(BLACK);
`ifndef FULL_CLEAR_EN
            prev_en <= '0;
`endif
        end else begin
            idx  <= idx_n;
            plot <= pix_vld;
            if (pix_vld) begin
                x      <= sc_px;
                y      <= sc_py;
                colour <= pix_colour;
            end
`ifndef FULL_CLEAR_EN
            if (state == FINISH) prev_en <= cur_en;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (state == LATCH) begin
            cur_en <= obj_en;
            cur_x  <= obj_x;
            cur_y  <= obj_y;
            cur_w  <= obj_w;
            cur_h  <= obj_h;
            cur_c  <= obj_colour;
            cur_bg <= bg_colour;
        end
`ifndef FULL_CLEAR_EN
        if (state == FINISH) begin
            prev_x <= cur_x;
            prev_y <= cur_y;
            prev_w <= cur_w;
            prev_h <= cur_h;
        end
`endif
    end

endmodule

// File: tb/tb_sprite_render_engine.sv
// Scoreboard bench for sprite_render_engine: expected pixels are queued per
// frame, a monitor pops and compares every plot.
module tb_sprite_render_engine;

    localparam int NUM_OBJ = 4;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int C_W     = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic [NUM_OBJ-1:0]       obj_en;
    logic [NUM_OBJ*X_W-1:0]   obj_x, obj_w;
    logic [NUM_OBJ*Y_W-1:0]   obj_y, obj_h;
    logic [NUM_OBJ*C_W-1:0]   obj_colour;
    logic [C_W-1:0]           bg_colour;
    logic                     plot, busy, done;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [C_W-1:0]           colour;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } pix_t;

    pix_t exp_q[$];
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    sprite_render_engine #(
        .SCREEN_W (160),
        .SCREEN_H (120),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOUR_W (C_W),
        .NUM_OBJ  (NUM_OBJ)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .obj_en     (obj_en),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_w      (obj_w),
        .obj_h      (obj_h),
        .obj_colour (obj_colour),
        .bg_colour  (bg_colour),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int px, input int py, input int pc);
        pix_t p;
        p.x = X_W'(px);
        p.y = Y_W'(py);
        p.c = C_W'(pc);
        exp_q.push_back(p);
    endtask

    task automatic set_obj(input int i, input bit en, input int ox, input int oy,
                           input int ow, input int oh, input int oc);
        obj_en[i]               = en;
        obj_x[i*X_W +: X_W]     = X_W'(ox);
        obj_y[i*Y_W +: Y_W]     = Y_W'(oy);
        obj_w[i*X_W +: X_W]     = X_W'(ow);
        obj_h[i*Y_W +: Y_W]     = Y_W'(oh);
        obj_colour[i*C_W +: C_W] = C_W'(oc);
    endtask

    // Monitor: every plot must match the head of the expected queue
    initial begin
        pix_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
            if (plot === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_plot: got (%0d,%0d) c=%0d, expected no plot",
                             x, y, colour);
                end else begin
                    e = exp_q.pop_front();
                    if ({x, y, colour} !== e) begin
                        n_bad++;
                        $display("FAIL pixel: got (%0d,%0d) c=%0d, expected (%0d,%0d) c=%0d",
                                 x, y, colour, e.x, e.y, e.c);
                    end
                end
            end
        end
    end

    // One frame: pulse start, count busy cycles (LATCH..FINISH), optionally
    // disturb inputs mid-frame or abort with reset at a given busy cycle.
    task automatic run_frame(input string name, input int exp_cyc,
                             input int abort_at, input bit disturb);
        int cnt;
        int d0;
        d0  = n_done;
        cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (busy === 1'b1 && cnt < 30000) begin
            cnt++;
            if (disturb && cnt == 5) begin
                start = 1'b1;
                obj_x[0 +: X_W] = 8'd90;
            end
            if (disturb && cnt == 6) start = 1'b0;
            if (abort_at != 0 && cnt == abort_at) resetn = 1'b0;
            @(negedge clk);
        end
        if (abort_at != 0) begin
            chk({name, "_abort_plot"}, int'(plot), 0);
            chk({name, "_abort_busy"}, int'(busy), 0);
            chk({name, "_abort_done"}, int'(done), 0);
            resetn = 1'b1;
        end else begin
            chk({name, "_cycles"}, cnt, exp_cyc);
        end
        repeat (3) @(negedge clk);
        chk({name, "_idle_after"}, int'(busy), 0);
        chk({name, "_done_pulses"}, n_done - d0, (abort_at != 0) ? 0 : 1);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        obj_en     = '0;
        obj_x      = '0;
        obj_y      = '0;
        obj_w      = '0;
        obj_h      = '0;
        obj_colour = '0;
        bg_colour  = '0;

        repeat (3) @(negedge clk);
        chk("reset_plot",   int'(plot),   0);
        chk("reset_x",      int'(x),      0);
        chk("reset_y",      int'(y),      0);
        chk("reset_colour", int'(colour), 0);
        chk("reset_busy",   int'(busy),   0);
        chk("reset_done",   int'(done),   0);
        resetn = 1'b1;
        @(negedge clk);

`ifdef FULL_CLEAR_EN
        set_obj(0, 1'b1, 10, 5, 2, 2, 4);
        set_obj(1, 1'b0, 50, 50, 3, 3, 6);
        bg_colour = 3'd2;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                push(xx, yy, 2);
        push(10, 5, 4); push(11, 5, 4); push(10, 6, 4); push(11, 6, 4);
        run_frame("fullclear", 2 + 19200 + 4 + 3, 0, 1'b0);
`else
        // Frame 1: first frame, nothing to erase; obj1 disabled despite size
        set_obj(0, 1'b1, 10, 5, 2, 2, 4);
        set_obj(1, 1'b0, 50, 50, 3, 3, 6);
        bg_colour = 3'd3;
        push(10, 5, 4); push(11, 5, 4); push(10, 6, 4); push(11, 6, 4);
        run_frame("f1", 13, 0, 1'b0);

        // Frame 2: move obj0; obj3 enabled but zero width is skipped
        set_obj(0, 1'b1, 20, 5, 2, 2, 4);
        set_obj(3, 1'b1, 70, 70, 0, 5, 5);
        bg_colour = 3'd0;
        push(10, 5, 0); push(11, 5, 0); push(10, 6, 0); push(11, 6, 0);
        push(20, 5, 4); push(21, 5, 4); push(20, 6, 4); push(21, 6, 4);
        run_frame("f2", 16, 0, 1'b0);

        // Frame 3: clipped at the bottom-right corner
        set_obj(0, 1'b1, 158, 119, 4, 2, 4);
        bg_colour = 3'd1;
        push(20, 5, 1); push(21, 5, 1); push(20, 6, 1); push(21, 6, 1);
        push(158, 119, 4); push(159, 119, 4);
        run_frame("f3_clip", 20, 0, 1'b0);

        // Frame 4: start re-pulsed and obj_x changed while busy
        set_obj(0, 1'b1, 30, 10, 1, 3, 2);
        set_obj(2, 1'b1, 0, 0, 1, 1, 7);
        set_obj(3, 1'b0, 0, 0, 0, 0, 0);
        bg_colour = 3'd0;
        push(158, 119, 0); push(159, 119, 0);
        push(30, 10, 2); push(30, 11, 2); push(30, 12, 2);
        push(0, 0, 7);
        run_frame("f4_busy", 19, 0, 1'b1);

        // Frame 5: reset lands on the third draw position of obj0
        set_obj(0, 1'b1, 40, 40, 3, 3, 5);
        set_obj(2, 1'b0, 0, 0, 0, 0, 0);
        bg_colour = 3'd0;
        push(30, 10, 0); push(30, 11, 0); push(30, 12, 0); push(0, 0, 0);
        push(40, 40, 5); push(41, 40, 5);
        run_frame("f5_reset", 0, 10, 1'b0);

        // Frame 6: prev snapshot was cleared by reset, so no erase pixels
        set_obj(0, 1'b1, 50, 50, 1, 1, 3);
        push(50, 50, 3);
        run_frame("f6_after_reset", 10, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
